// File: rtl/sorted_spike_tx_16.sv
`default_nettype none
// ============================================================================
//  Module   : sorted_spike_tx_16
//  Purpose  : Accepts a sorted 16-bit thermometer word, checks that it is a
//             legal code, decodes it to a 0..16 count and replays that count
//             as a 16-slot unary spike train on one wire. Each slot lasts
//             SLOT_CYCLES clock cycles.
//  Ports    :
//    clk          rising-edge clock
//    rst          synchronous active-high reset
//    sorted_in    sorted word; bit 0 = min, bit 15 = max
//    in_valid     sorted_in is valid
//    in_ready     block can accept; transfer on in_valid & in_ready
//    count        popcount of the last accepted word (held)
//    count_valid  one-cycle pulse when count updates
//    code_err     last accepted word was not a thermometer code (held)
//    spike_out    unary spike train, high for slots 0..count-1
//    frame_start  pulse on the first cycle of slot 0
//    frame_done   pulse on the last cycle of slot 15
//  Revision : 1.0 - initial release
// ============================================================================
module sorted_spike_tx_16 #(
  parameter int SLOT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] sorted_in,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [4:0]  count,
  output logic        count_valid,
  output logic        code_err,
  output logic        spike_out,
  output logic        frame_start,
  output logic        frame_done
);

  // The sub-counter needs at least one bit even when a slot is one cycle long.
  localparam int SW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [SW-1:0] C_SUB_LAST = SW'(SLOT_CYCLES - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_EMIT = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    slot_q, slot_d;
  logic [SW-1:0] sub_q, sub_d;
  logic [4:0]    count_q, count_d;
  logic          err_q, err_d;
  logic          spike_q, spike_d;
  logic          cv_q, cv_d;
  logic          fs_q, fs_d;
  logic          fd_q, fd_d;

  logic          w_last;
  logic          w_accept;
  logic [4:0]    w_pop;
  logic          w_err;

  // Last cycle of slot 15: the frame may hand over to a new word here.
  assign w_last   = (state_q == S_EMIT) && (slot_q == 4'd15) && (sub_q == C_SUB_LAST);
  assign in_ready = !rst && ((state_q == S_IDLE) || w_last);
  assign w_accept = in_valid && in_ready;

  // Popcount is taken regardless of code legality.
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < 16; i++) begin
      w_pop = w_pop + {4'd0, sorted_in[i]};
    end
  end

  // A 1 directly below a 0 breaks the thermometer ordering.
  assign w_err = |(sorted_in[14:0] & ~sorted_in[15:1]);

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    sub_d   = sub_q;
    count_d = count_q;
    err_d   = err_q;

    if (w_accept) begin
      state_d = S_EMIT;
      slot_d  = 4'd0;
      sub_d   = '0;
      count_d = w_pop;
      err_d   = w_err;
    end else if (state_q == S_EMIT) begin
      if (sub_q == C_SUB_LAST) begin
        sub_d = '0;
        if (slot_q == 4'd15) begin
          state_d = S_IDLE;
          slot_d  = 4'd0;
        end else begin
          slot_d = slot_q + 4'd1;
        end
      end else begin
        sub_d = sub_q + SW'(1);
      end
    end

    // Outputs are registered from the next-state view so they line up with
    // the slot/sub-counter values they describe.
    spike_d = (state_d == S_EMIT) && ({1'b0, slot_d} < count_d);
    cv_d    = w_accept;
    fs_d    = w_accept;
    fd_d    = (state_d == S_EMIT) && (slot_d == 4'd15) && (sub_d == C_SUB_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      slot_q  <= 4'd0;
      sub_q   <= '0;
      count_q <= 5'd0;
      err_q   <= 1'b0;
      spike_q <= 1'b0;
      cv_q    <= 1'b0;
      fs_q    <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      sub_q   <= sub_d;
      count_q <= count_d;
      err_q   <= err_d;
      spike_q <= spike_d;
      cv_q    <= cv_d;
      fs_q    <= fs_d;
      fd_q    <= fd_d;
    end
  end

  assign count       = count_q;
  assign code_err    = err_q;
  assign spike_out   = spike_q;
  assign count_valid = cv_q;
  assign frame_start = fs_q;
  assign frame_done  = fd_q;

endmodule
`default_nettype wire

// File: tb/tb_sorted_spike_tx_16.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sorted_spike_tx_16
//  Purpose  : Directed self-checking bench for sorted_spike_tx_16 with one
//             instance at SLOT_CYCLES=1 and one at SLOT_CYCLES=3.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sorted_spike_tx_16;

  logic        clk;
  logic        rst;

  logic [15:0] d1;
  logic        v1;
  logic        rdy1;
  logic [4:0]  cnt1;
  logic        cv1, err1, spk1, fs1, fd1;

  logic [15:0] d3;
  logic        v3;
  logic        rdy3;
  logic [4:0]  cnt3;
  logic        cv3, err3, spk3, fs3, fd3;

  int n_cmp;
  int n_bad;

  sorted_spike_tx_16 #(.SLOT_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .sorted_in(d1), .in_valid(v1), .in_ready(rdy1),
    .count(cnt1), .count_valid(cv1), .code_err(err1), .spike_out(spk1),
    .frame_start(fs1), .frame_done(fd1)
  );

  sorted_spike_tx_16 #(.SLOT_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .sorted_in(d3), .in_valid(v3), .in_ready(rdy3),
    .count(cnt3), .count_valid(cv3), .code_err(err3), .spike_out(spk3),
    .frame_start(fs3), .frame_done(fd3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [8:0] obs;
    rst = 1'b1; v1 = 1'b1; d1 = 16'hFFFF; v3 = 1'b1; d3 = 16'hFFFF;
    for (int c = 0; c < 2; c++) begin
      step();
      obs = {rdy1, cnt1, err1, spk1, cv1};
      n_cmp++;
      if (obs !== 9'd0) begin
        n_bad++;
        $display("FAIL reset_s1 cyc%0d {rdy,cnt,err,spk,cv}: got %b want %b", c, obs, 9'd0);
      end
      obs = {rdy3, fs1, fd1, fs3, fd3, spk3, cv3, err3, 1'b0};
      n_cmp++;
      if (obs !== 9'd0) begin
        n_bad++;
        $display("FAIL reset_misc cyc%0d: got %b want %b", c, obs, 9'd0);
      end
    end
    rst = 1'b0; v1 = 1'b0; v3 = 1'b0;
    step();
    n_cmp++;
    if ({rdy1, rdy3} !== 2'b11) begin
      n_bad++;
      $display("FAIL reset_ready_after: got %b want 11", {rdy1, rdy3});
    end
    n_cmp++;
    if ({cnt1, spk1, cv1, fs1} !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_no_accept: got cnt=%0d spk=%b cv=%b fs=%b want all 0", cnt1, spk1, cv1, fs1);
    end
  endtask

  // One 16-slot frame at S=1 for an 8-count word; expected error flag given.
  task automatic frame8_s1(input logic [15:0] word, input logic exp_err, input string name);
    logic [3:0] obs, exp;
    n_cmp++;
    if (rdy1 !== 1'b1) begin
      n_bad++;
      $display("FAIL %s ready_pre: got %b want 1", name, rdy1);
    end
    v1 = 1'b1; d1 = word;
    step();
    v1 = 1'b0;
    n_cmp++;
    if ({cnt1, err1, rdy1} !== {5'd8, exp_err, 1'b0}) begin
      n_bad++;
      $display("FAIL %s capture: got cnt=%0d err=%b rdy=%b want cnt=8 err=%b rdy=0", name, cnt1, err1, rdy1, exp_err);
    end
    for (int k = 1; k <= 16; k++) begin
      if (k > 1) step();
      obs = {spk1, fd1, fs1, cv1};
      exp = {(k <= 8), (k == 16), (k == 1), (k == 1)};
      n_cmp++;
      if (obs !== exp) begin
        n_bad++;
        $display("FAIL %s slot%0d {spk,fd,fs,cv}: got %b want %b", name, k - 1, obs, exp);
      end
    end
    n_cmp++;
    if ({rdy1, err1} !== {1'b1, exp_err}) begin
      n_bad++;
      $display("FAIL %s last_cycle {rdy,err}: got %b%b want 1%b", name, rdy1, err1, exp_err);
    end
    step();
    n_cmp++;
    if ({rdy1, spk1, fd1, cnt1, err1} !== {1'b1, 1'b0, 1'b0, 5'd8, exp_err}) begin
      n_bad++;
      $display("FAIL %s idle_after: got rdy=%b spk=%b fd=%b cnt=%0d err=%b", name, rdy1, spk1, fd1, cnt1, err1);
    end
  endtask

  task automatic test_legal();
    frame8_s1(16'hFF00, 1'b0, "legal");
  endtask

  task automatic test_illegal();
    frame8_s1(16'h00FF, 1'b1, "illegal");
  endtask

  task automatic test_back_to_back();
    logic [3:0] obs, exp;
    v1 = 1'b1; d1 = 16'hFFFF;
    step();
    d1 = 16'h0000;
    for (int k = 1; k <= 33; k++) begin
      if (k > 1) step();
      if (k == 17) v1 = 1'b0;
      obs = {spk1, fd1, fs1, cv1};
      exp = {(k <= 16), (k == 16 || k == 32), (k == 1 || k == 17), (k == 1 || k == 17)};
      n_cmp++;
      if (obs !== exp) begin
        n_bad++;
        $display("FAIL b2b cyc%0d {spk,fd,fs,cv}: got %b want %b", k, obs, exp);
      end
      if (k == 1 || k == 17) begin
        n_cmp++;
        if (cnt1 !== ((k == 1) ? 5'd16 : 5'd0)) begin
          n_bad++;
          $display("FAIL b2b count cyc%0d: got %0d want %0d", k, cnt1, (k == 1) ? 16 : 0);
        end
      end
    end
    n_cmp++;
    if (rdy1 !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b idle_ready: got %b want 1", rdy1);
    end
  endtask

  task automatic test_mid_reset();
    int fd_seen;
    v1 = 1'b1; d1 = 16'hFFFF;
    step();                      // cycle T+1
    v1 = 1'b0;
    for (int k = 2; k <= 5; k++) step();
    rst = 1'b1;                  // asserted during cycle T+5
    #1;
    n_cmp++;
    if (rdy1 !== 1'b0) begin
      n_bad++;
      $display("FAIL midrst ready_in_rst: got %b want 0", rdy1);
    end
    step();                      // cycle T+6
    n_cmp++;
    if ({spk1, rdy1, cnt1, fd1, cv1, fs1} !== 10'd0) begin
      n_bad++;
      $display("FAIL midrst after: got spk=%b rdy=%b cnt=%0d fd=%b", spk1, rdy1, cnt1, fd1);
    end
    rst = 1'b0;
    fd_seen = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (fd1) fd_seen++;
    end
    n_cmp++;
    if (fd_seen !== 0) begin
      n_bad++;
      $display("FAIL midrst no_frame_done: got %0d pulses want 0", fd_seen);
    end
    frame8_s1(16'hFF00, 1'b0, "post_reset");
  endtask

  task automatic test_slot3();
    logic [1:0] obs, exp;
    for (int w = 0; w < 2; w++) begin
      n_cmp++;
      if (rdy3 !== 1'b1) begin
        n_bad++;
        $display("FAIL s3 w%0d ready_pre: got %b want 1", w, rdy3);
      end
      v3 = 1'b1; d3 = (w == 0) ? 16'h8000 : 16'h0000;
      step();
      v3 = 1'b0;
      n_cmp++;
      if ({cnt3, err3, fs3, cv3} !== {((w == 0) ? 5'd1 : 5'd0), 1'b0, 1'b1, 1'b1}) begin
        n_bad++;
        $display("FAIL s3 w%0d capture: got cnt=%0d err=%b fs=%b cv=%b", w, cnt3, err3, fs3, cv3);
      end
      for (int k = 1; k <= 48; k++) begin
        if (k > 1) step();
        obs = {spk3, fd3};
        exp = {(w == 0 && k <= 3), (k == 48)};
        n_cmp++;
        if (obs !== exp) begin
          n_bad++;
          $display("FAIL s3 w%0d cyc%0d {spk,fd}: got %b want %b", w, k, obs, exp);
        end
      end
      step();
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_legal();
    test_illegal();
    test_back_to_back();
    test_mid_reset();
    test_slot3();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
